// File: rtl/collision_handler.sv
// -----------------------------------------------------------------------------
// collision_handler
//
// Purpose:
//   Watches obstacle pixel reports from the obstacle stage and compares them
//   against the player box anchored at the mouse cursor. Records at most one
//   collision per frame, charges one HP at the next frame start, then opens an
//   invulnerability window of INVULN_FRAMES frames. Raises game_over when HP
//   reaches 0. The pixel stream is passed through with one cycle of delay.
//
// Optional feature (macro HIT_FLASH_EN):
//   While invulnerable, the player box blinks in FLASH_COLOR (8 frames on,
//   8 frames off). When undefined, rgb_out is rgb_in delayed one cycle.
//
// Ports:
//   pclk        in   1   pixel clock
//   rst         in   1   asynchronous, active-low reset
//   hcount_in   in  12   current pixel column, aligned with rgb_in
//   vcount_in   in  12   current pixel row, aligned with rgb_in
//   rgb_in      in  12   pixel colour from the upstream stage
//   game_on     in   1   1 = gameplay active, 0 = idle/menu
//   obstacle_x  in  12   column of an obstacle pixel (0,0 = none)
//   obstacle_y  in  12   row of that obstacle pixel
//   mouse_xpos  in  12   player box left edge
//   mouse_ypos  in  12   player box top edge
//   rgb_out     out 12   rgb_in delayed one cycle (optionally tinted)
//   hp          out  4   current HP
//   hit         out  1   one-cycle pulse when damage is applied
//   invuln      out  1   high while the invulnerability window runs
//   game_over   out  1   high once HP has reached 0
// -----------------------------------------------------------------------------
module collision_handler #(
   parameter int          PLAYER_SIZE   = 16,
   parameter int          HP_MAX        = 5,
   parameter int          INVULN_FRAMES = 60,
   parameter logic [11:0] FLASH_COLOR   = 12'hf00
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic [11:0] hcount_in,
   input  logic [11:0] vcount_in,
   input  logic [11:0] rgb_in,
   input  logic        game_on,
   input  logic [11:0] obstacle_x,
   input  logic [11:0] obstacle_y,
   input  logic [11:0] mouse_xpos,
   input  logic [11:0] mouse_ypos,
   output logic [11:0] rgb_out,
   output logic [3:0]  hp,
   output logic        hit,
   output logic        invuln,
   output logic        game_over
);

   typedef enum logic [1:0] {IDLE, ARMED, INVULN, OVER} state_t;

   localparam logic [12:0] BOX_M1 = 13'(PLAYER_SIZE - 1);

   state_t      state, state_nxt;
   logic        hit_flag;
   logic [7:0]  inv_cnt;
   logic        frame_tick;
   logic        coll;
   logic        damage;
   logic        inv_done;
   logic [12:0] box_x_hi, box_y_hi;

   // Upper box bounds are kept at 13 bits so a box near 4095 does not wrap.
   assign box_x_hi   = {1'b0, mouse_xpos} + BOX_M1;
   assign box_y_hi   = {1'b0, mouse_ypos} + BOX_M1;
   assign frame_tick = (hcount_in == 12'd0) && (vcount_in == 12'd0);
   assign coll       = ((obstacle_x | obstacle_y) != 12'd0)
                       && (obstacle_x >= mouse_xpos) && ({1'b0, obstacle_x} <= box_x_hi)
                       && (obstacle_y >= mouse_ypos) && ({1'b0, obstacle_y} <= box_y_hi);

   // Damage is charged at the frame start that follows a colliding frame.
   assign damage   = (state == ARMED) && game_on && frame_tick && hit_flag;
   assign inv_done = (state == INVULN) && frame_tick && (inv_cnt == 8'd1);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      // NOTE: default assignment first so no path through this block infers a latch.
      state_nxt = state;
      if (!game_on) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE:    state_nxt = ARMED;
            ARMED:   if (damage) state_nxt = (hp == 4'd1) ? OVER : INVULN;
            INVULN:  if (inv_done) state_nxt = ARMED;
            OVER:    state_nxt = OVER;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      invuln    = (state == INVULN);
      game_over = (state == OVER);
   end

   // ---------------- HP, hit pulse, per-frame flag, window counter ----------------
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values, independent of statement order.
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         hp       <= 4'(HP_MAX);
         hit      <= 1'b0;
         hit_flag <= 1'b0;
         inv_cnt  <= 8'd0;
      end else begin
         hit <= damage;
         if (!game_on) begin
            // Leaving gameplay discards any partial frame and reloads HP.
            hp       <= 4'(HP_MAX);
            hit_flag <= 1'b0;
            inv_cnt  <= 8'd0;
         end else begin
            unique case (state)
               IDLE: begin
                  hp       <= 4'(HP_MAX);
                  hit_flag <= 1'b0;
                  inv_cnt  <= 8'd0;
               end
               ARMED: begin
                  // A collision on the tick itself belongs to the new frame.
                  if (frame_tick) hit_flag <= coll;
                  else            hit_flag <= hit_flag | coll;
                  if (damage) begin
                     hp      <= hp - 4'd1;
                     inv_cnt <= 8'(INVULN_FRAMES);
                  end
               end
               INVULN: begin
                  hit_flag <= 1'b0;
                  if (frame_tick && (inv_cnt != 8'd0)) inv_cnt <= inv_cnt - 8'd1;
               end
               OVER: begin
                  hp       <= 4'd0;
                  hit_flag <= 1'b0;
                  inv_cnt  <= 8'd0;
               end
               default: begin
                  hit_flag <= 1'b0;
                  inv_cnt  <= 8'd0;
               end
            endcase
         end
      end
   end

   // ---------------- Pixel pass-through ----------------
`ifdef HIT_FLASH_EN
   logic [12:0] pix_x_ext, pix_y_ext;
   logic        pix_in_box;
   logic        flash_on;

   // Box test uses the pixel being presented this cycle, not the obstacle report.
   assign pix_x_ext  = {1'b0, hcount_in};
   assign pix_y_ext  = {1'b0, vcount_in};
   assign pix_in_box = (hcount_in >= mouse_xpos) && (pix_x_ext <= box_x_hi)
                       && (vcount_in >= mouse_ypos) && (pix_y_ext <= box_y_hi);
   assign flash_on   = invuln && inv_cnt[3] && pix_in_box;

   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) rgb_out <= 12'd0;
      else      rgb_out <= flash_on ? FLASH_COLOR : rgb_in;
   end
`else
   logic unused_flash_color;
   assign unused_flash_color = ^FLASH_COLOR;

   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) rgb_out <= 12'd0;
      else      rgb_out <= rgb_in;
   end
`endif

endmodule

// File: tb/tb_collision_handler.sv
`timescale 1ns/1ps
module tb_collision_handler;

   localparam int          PS    = 16;
   localparam int          HPM   = 5;
   localparam int          INVF  = 60;
   localparam logic [11:0] FLASH = 12'hf00;

   logic        pclk, rst;
   logic [11:0] hcount_in, vcount_in, rgb_in;
   logic        game_on;
   logic [11:0] obstacle_x, obstacle_y, mouse_xpos, mouse_ypos;
   logic [11:0] rgb_out;
   logic [3:0]  hp;
   logic        hit, invuln, game_over;

   collision_handler #(.PLAYER_SIZE(PS), .HP_MAX(HPM), .INVULN_FRAMES(INVF),
                       .FLASH_COLOR(FLASH)) dut (
      .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
      .rgb_in(rgb_in), .game_on(game_on), .obstacle_x(obstacle_x),
      .obstacle_y(obstacle_y), .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
      .rgb_out(rgb_out), .hp(hp), .hit(hit), .invuln(invuln), .game_over(game_over));

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: gameplay described in frames and HP, not in FSM states.
   int m_hp, m_inv;          // HP; frames of invulnerability still to run
   bit m_active, m_over;     // gameplay started; game ended
   bit m_pending;            // this frame has seen a collision
   bit m_hit;

   task automatic check(string name, int act, int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic bit in_box(int px, int py);
      return px >= int'(mouse_xpos) && px <= int'(mouse_xpos) + PS - 1 &&
             py >= int'(mouse_ypos) && py <= int'(mouse_ypos) + PS - 1;
   endfunction

   task automatic model_reset();
      m_hp = HPM; m_inv = 0; m_active = 0; m_over = 0; m_pending = 0; m_hit = 0;
   endtask

   // Advance one clock: predict from the current inputs, clock, compare.
   task automatic step();
      bit          tick, c;
      logic [11:0] e_rgb;
      tick  = (hcount_in == 0) && (vcount_in == 0);
      c     = ((obstacle_x | obstacle_y) != 0) && in_box(int'(obstacle_x), int'(obstacle_y));
      e_rgb = rgb_in;
`ifdef HIT_FLASH_EN
      if (m_inv > 0 && (m_inv & 8) != 0 && in_box(int'(hcount_in), int'(vcount_in)))
         e_rgb = FLASH;
`endif
      m_hit = 0;
      if (!game_on) begin
         model_reset();
      end else if (!m_active) begin
         m_active = 1;
      end else if (m_over) begin
         m_pending = 0;
      end else if (m_inv > 0) begin
         m_pending = 0;
         if (tick) m_inv--;
      end else begin
         if (tick && m_pending) begin
            m_hit = 1;
            m_hp--;
            if (m_hp == 0) m_over = 1;
            else           m_inv = INVF;
         end
         m_pending = tick ? c : (m_pending | c);
         if (m_hit) m_pending = 0;
      end
      @(posedge pclk); #1;
      check("hp", hp, m_hp);
      check("hit", hit, m_hit);
      check("invuln", invuln, m_inv > 0);
      check("game_over", game_over, m_over);
      check("rgb_out", rgb_out, e_rgb);
   endtask

   task automatic cyc(int ox, int oy, int hc, int vc);
      obstacle_x = 12'(ox); obstacle_y = 12'(oy);
      hcount_in  = 12'(hc); vcount_in  = 12'(vc);
      rgb_in     = 12'($urandom);
      step();
   endtask

   task automatic frame_tick_cyc(); cyc(0, 0, 0, 0); endtask
   task automatic idle_cyc();       cyc(0, 0, 100, 100); endtask

   task automatic restart();
      game_on = 0; idle_cyc();
      game_on = 1; idle_cyc();
   endtask

   typedef struct {
      string name;
      int mx, my, ox, oy;
      bit exp_hit;
   } vec_t;

   vec_t vecs[8];

   initial begin
      vecs[0] = '{"inside",        500, 400,  505,  405, 1'b1};
      vecs[1] = '{"right_edge_out",500, 400,  516,  400, 1'b0};
      vecs[2] = '{"origin_none",   500, 400,    0,    0, 1'b0};
      vecs[3] = '{"top_left",      500, 400,  500,  400, 1'b1};
      vecs[4] = '{"bot_right",     500, 400,  515,  415, 1'b1};
      vecs[5] = '{"left_out",      500, 400,  499,  405, 1'b0};
      vecs[6] = '{"below_out",     500, 400,  505,  416, 1'b0};
      vecs[7] = '{"corner_4095",  4090,4090, 4095, 4095, 1'b1};

      rst = 0; game_on = 0; rgb_in = 0; hcount_in = 100; vcount_in = 100;
      obstacle_x = 0; obstacle_y = 0; mouse_xpos = 500; mouse_ypos = 400;
      model_reset();
      #12;
      check("rst_hp", hp, HPM);
      check("rst_hit", hit, 0);
      check("rst_invuln", invuln, 0);
      check("rst_game_over", game_over, 0);
      check("rst_rgb", rgb_out, 0);
      #5 rst = 1;

      // Single hit: one pixel, then frame start.
      game_on = 1; idle_cyc();
      cyc(505, 405, 100, 100);
      frame_tick_cyc();
      check("t1_hit_pulse", hit, 1);
      idle_cyc();
      check("t1_hit_width", hit, 0);
      check("t1_hp", hp, 4);
      check("t1_invuln", invuln, 1);

      // Collisions during invulnerability are ignored; window is 60 frames.
      for (int i = 0; i < INVF; i++) begin
         cyc(505, 405, 100, 100);
         check("t3_invuln_held", invuln, 1);
         frame_tick_cyc();
      end
      check("t3_invuln_end", invuln, 0);
      check("t3_hp_held", hp, 4);
      cyc(510, 410, 100, 100);
      frame_tick_cyc();
      idle_cyc();
      check("t3_second_hit", hp, 3);

      // Fifty overlapping pixels in one frame cost one HP.
      restart();
      for (int i = 0; i < 50; i++) cyc(500 + (i % 16), 400 + (i % 16), 100 + i, 100);
      frame_tick_cyc();
      idle_cyc();
      check("t2_single_dec", hp, 4);

      // Five spaced hits end the game; further hits are ignored.
      restart();
      for (int h = 0; h < HPM; h++) begin
         cyc(505, 405, 100, 100);
         frame_tick_cyc();
         for (int f = 0; f < INVF + 1; f++) begin idle_cyc(); frame_tick_cyc(); end
      end
      check("t4_hp_zero", hp, 0);
      check("t4_game_over", game_over, 1);
      cyc(505, 405, 100, 100);
      frame_tick_cyc();
      check("t4_no_hit_over", hit, 0);
      idle_cyc();
      check("t4_hp_stays", hp, 0);
      game_on = 0; idle_cyc();
      check("t4_reload_hp", hp, HPM);
      check("t4_clear_over", game_over, 0);

      // Box boundary table.
      foreach (vecs[k]) begin
         mouse_xpos = 12'(vecs[k].mx); mouse_ypos = 12'(vecs[k].my);
         restart();
         cyc(vecs[k].ox, vecs[k].oy, 100, 100);
         frame_tick_cyc();
         check({"vec_hit_", vecs[k].name}, hit, vecs[k].exp_hit);
         idle_cyc();
         check({"vec_hp_", vecs[k].name}, hp, vecs[k].exp_hit ? HPM - 1 : HPM);
      end

      // Randomized play against the model.
      mouse_xpos = 500; mouse_ypos = 400;
      restart();
      for (int n = 0; n < 6000; n++) begin
         int r, ox, oy, hc, vc;
         r = $urandom_range(0, 99);
         game_on = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 63) == 0) begin
            mouse_xpos = 12'($urandom); mouse_ypos = 12'($urandom);
         end
         if (r < 25) begin
            ox = int'(12'(int'(mouse_xpos) + $urandom_range(0, PS)));
            oy = int'(12'(int'(mouse_ypos) + $urandom_range(0, PS)));
         end else begin
            ox = (r < 35) ? 0 : int'(12'($urandom));
            oy = (r < 35) ? 0 : int'(12'($urandom));
         end
         if ($urandom_range(0, 3) == 0) begin hc = 0; vc = 0; end
         else if ($urandom_range(0, 1) == 0) begin
            hc = int'(12'(int'(mouse_xpos) + $urandom_range(0, PS)));
            vc = int'(12'(int'(mouse_ypos) + $urandom_range(0, PS)));
         end else begin
            hc = $urandom_range(1, 4095); vc = $urandom_range(0, 4095);
         end
         cyc(ox, oy, hc, vc);
      end

      // Asynchronous reset in the middle of the invulnerability window.
      game_on = 1; mouse_xpos = 500; mouse_ypos = 400;
      restart();
      cyc(505, 405, 100, 100);
      frame_tick_cyc();
      for (int f = 0; f < 12; f++) begin cyc(505, 405, 505, 405); frame_tick_cyc(); end
      check("t6_pre_invuln", invuln, 1);
      #3 rst = 0;
      #1;
      check("t6_async_hp", hp, HPM);
      check("t6_async_hit", hit, 0);
      check("t6_async_invuln", invuln, 0);
      check("t6_async_over", game_over, 0);
      check("t6_async_rgb", rgb_out, 0);
      model_reset();
      @(posedge pclk); #1;
      check("t6_held_invuln", invuln, 0);
      rst = 1;
      idle_cyc();
      cyc(505, 405, 100, 100);
      frame_tick_cyc();
      idle_cyc();
      check("t6_after_reset_hit", hp, HPM - 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
